param_step_counter: RTL and testbench
=====================================

Name: param_step_counter

Overview:
- Parametrised successor to the fixed 8-bit even up-counter.
- Counts in steps of 2 over a WIDTH-bit value. The LSB selects the even or odd sequence at run time.
- Adds run-time direction, clock enable, synchronous parallel load, wrap or saturate at the limits, a terminal-count pulse and a sticky overflow flag.
- Used as a general sequence/address generator wherever stride-2 counts are needed.

Parameters:
- WIDTH, 8, total counter width in bits; must be >= 2.
- SATURATE, 0, selects limit handling: 0 = wrap at the limit; 1 = hold at the limit.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  count enable; sampled on the clk rising edge.
- dir  in  1  count direction: 0 = up (+2), 1 = down (-2).
- odd  in  1  sequence parity: 0 = even values, 1 = odd values.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  load value; bit 0 is ignored.
- clr_ovf  in  1  synchronous clear of ovf.
- q  out  WIDTH  counter value, registered.
- tc  out  1  terminal-count pulse, registered.
- ovf  out  1  sticky overflow/limit flag, registered.
- at_limit  out  1  combinational; 1 when the next step would hit the limit.

Behaviour:
- Internal split: q = {c, p}, where c is the WIDTH-1-bit step field and p is the parity bit. One step changes c by +/-1, so q changes by +/-2.
- Reset (reset=0, asynchronous, any time including mid-count):
  - q=0, tc=0, ovf=0 immediately.
  - No clk edge has effect while reset=0.
  - The first edge after reset is released behaves normally.
- Priority per rising edge: load > en > hold.
- load=1:
  - c <= load_val[WIDTH-1:1], p <= odd.
  - tc <= 0. ovf unaffected, except for clr_ovf.
  - en is ignored this cycle.
- en=1, load=0: p <= odd, so a parity change takes effect on the same step.
  - Up, c != all-ones: c <= c+1.
  - Up, c == all-ones: c <= 0 if SATURATE=0; c holds if SATURATE=1. tc <= 1, ovf <= 1.
  - Down, c != 0: c <= c-1.
  - Down, c == 0: c <= all-ones if SATURATE=0; c holds if SATURATE=1. tc <= 1, ovf <= 1.
- en=0, load=0: c and p hold; tc <= 0.
- tc:
  - High for exactly the one cycle following each limit-hit step.
  - With SATURATE=1 and en held at the limit, tc stays high every cycle.
- ovf:
  - Set by any limit hit; cleared by clr_ovf.
  - If clr_ovf and a limit hit occur in the same cycle, set wins.
- at_limit = (dir=0 and c==all-ones) or (dir=1 and c==0). Independent of en.
- Latency: one clock from sampled en/load to the updated q.
- Changing dir mid-count applies to the next enabled step. No glitch cycle, no skipped value.

Decomposition:
- Shared package psc_pkg:
  - dir_e enum {DIR_UP=0, DIR_DOWN=1}.
  - limit-mode constants LIM_WRAP=0, LIM_SAT=1.
- Sub-module step_slice:
  - Single-bit up/down toggle cell with carry/borrow in and out (xor + and/or chain).
  - Instantiated WIDTH-1 times via generate to form c.
  - Top level holds load muxing, parity register, limit detection, tc/ovf registers.

Test Plan (WIDTH=8):
1. Reset pulse low then high; en=1, dir=0, odd=0, SATURATE=0 → q=0x00,0x02,…,0xFE,0x00. tc=1 only in the cycle q=0x00 after the wrap; ovf=1 from then on.
2. load=1, load_val=0x10, odd=1 → q=0x11; then en=1 for 3 cycles → 0x13, 0x15, 0x17. Then odd=0 for one enabled cycle → 0x18.
3. load_val=0x02, odd=0, dir=1, en=1 → q=0x00 (at_limit=1), then 0xFE with tc=1 and ovf=1. Pulse clr_ovf=1 alone → ovf=0.
4. SATURATE=1, load 0xFC, dir=0, en=1 for 4 cycles → q=0xFE, 0xFE, 0xFE, 0xFE. tc=0 on the first cycle, then 1,1,1. clr_ovf asserted during a limit hit → ovf stays 1.
5. load=1 and en=1 together, load_val=0x40, q=0x20 → q=0x40, tc=0.
6. Assert reset low asynchronously between edges with q=0x36, ovf=1 → q=0x00, tc=0, ovf=0 immediately. After release, en=1 → q=0x02.

Source files
------------

// File: rtl/param_step_counter_pkg.sv
// Shared types and constants for the stride-2 step counter.
package psc_pkg;

  // Count direction as seen on the dir input.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Limit handling selected by the SATURATE parameter.
  localparam int LIM_WRAP = 0;
  localparam int LIM_SAT  = 1;

endpackage

// File: rtl/param_step_counter_if.sv
// Control and status bundle of the step counter; clk and reset stay outside.
interface param_step_counter_if #(
  parameter int WIDTH = 8
);

  logic             en;
  logic             dir;
  logic             odd;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_ovf;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;
  logic             at_limit;

  // Driver side: issues commands, observes the count.
  modport master (
    output en, dir, odd, load, load_val, clr_ovf,
    input  q, tc, ovf, at_limit
  );

  // Counter side.
  modport slave (
    input  en, dir, odd, load, load_val, clr_ovf,
    output q, tc, ovf, at_limit
  );

endinterface

// File: rtl/param_step_counter_step_slice.sv
// One bit of the up/down step field: toggles when carry/borrow arrives and
// propagates it onward when this bit is 1 (up) or 0 (down).
module step_slice
  import psc_pkg::*;
(
  input  logic bit_i,
  input  dir_e dir_i,
  input  logic cin_i,
  output logic bit_o,
  output logic cout_o
);

  assign bit_o  = bit_i ^ cin_i;
  assign cout_o = cin_i & (bit_i ^ (dir_i == DIR_DOWN));

endmodule

// File: rtl/param_step_counter.sv
// Stride-2 up/down counter: q = {c, p}, c steps by one, p picks even/odd.
// Wrap or saturate at the limits, with terminal-count pulse and sticky overflow.
module param_step_counter
  import psc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = LIM_WRAP
) (
  input  logic                  clk,
  input  logic                  reset,
  param_step_counter_if.slave   bus
);

  localparam int CW = WIDTH - 1;

  logic [CW-1:0] c_q, c_d, c_step;
  logic          p_q, p_d;
  logic          tc_q, tc_d;
  logic          ovf_q, ovf_d;
  logic [CW:0]   carry;
  logic          limit_hit;
  dir_e          dir_s;
  logic          unused_lv0;

  assign dir_s      = dir_e'(bus.dir);
  assign unused_lv0 = bus.load_val[0];

  // The chain always injects one step; a carry out of the top slice means
  // this step crosses the limit (all-ones going up, zero going down).
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < CW; i++) begin : g_slice
    step_slice u_slice (
      .bit_i  (c_q[i]),
      .dir_i  (dir_s),
      .cin_i  (carry[i]),
      .bit_o  (c_step[i]),
      .cout_o (carry[i+1])
    );
  end

  assign limit_hit = carry[CW];

  // Next state: load beats enable beats hold; a limit hit sets ovf over clr_ovf.
  always_comb begin
    c_d   = c_q;
    p_d   = p_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (bus.clr_ovf) ovf_d = 1'b0;
    if (bus.load) begin
      c_d = bus.load_val[WIDTH-1:1];
      p_d = bus.odd;
    end else if (bus.en) begin
      p_d  = bus.odd;
      tc_d = limit_hit;
      if (limit_hit) ovf_d = 1'b1;
      // Wrapping falls out of the toggle chain; saturation just holds c.
      if (!(limit_hit && (SATURATE == LIM_SAT))) c_d = c_step;
    end
  end

  // State registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q   <= '0;
      p_q   <= 1'b0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      c_q   <= c_d;
      p_q   <= p_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.q        = {c_q, p_q};
  assign bus.tc       = tc_q;
  assign bus.ovf      = ovf_q;
  assign bus.at_limit = limit_hit;

endmodule

// File: tb/tb_param_step_counter.sv
// Bench for param_step_counter: a wrapping and a saturating instance driven
// with the same stimulus, each checked against its own reference model.
module tb_param_step_counter;
  import psc_pkg::*;

  logic clk = 1'b0;
  logic reset;

  param_step_counter_if #(.WIDTH(8)) bus0 ();
  param_step_counter_if #(.WIDTH(8)) bus1 ();

  param_step_counter #(.WIDTH(8), .SATURATE(LIM_WRAP)) u_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  param_step_counter #(.WIDTH(8), .SATURATE(LIM_SAT)) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic       tc;
    logic       ovf;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  logic [7:0] mq   [2];
  logic       mtc  [2];
  logic       movf [2];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Reference behaviour; instance 1 saturates, instance 0 wraps.
  function automatic void model_step(input int k, input logic e, input logic d, input logic o,
                                     input logic ld, input logic [7:0] lv, input logic clr);
    logic [6:0] c;
    logic       hit;
    c   = mq[k][7:1];
    hit = 1'b0;
    if (ld) begin
      c      = lv[7:1];
      mtc[k] = 1'b0;
      if (clr) movf[k] = 1'b0;
      mq[k]  = {c, o};
    end else if (e) begin
      hit = d ? (c == 7'd0) : (c == 7'h7F);
      if (hit) begin
        if (k == 0) c = d ? 7'h7F : 7'd0;
      end else begin
        c = d ? c - 7'd1 : c + 7'd1;
      end
      mtc[k] = hit;
      if (hit) movf[k] = 1'b1;
      else if (clr) movf[k] = 1'b0;
      mq[k] = {c, o};
    end else begin
      mtc[k] = 1'b0;
      if (clr) movf[k] = 1'b0;
    end
  endfunction

  task automatic set_inputs(input logic e, input logic d, input logic o,
                            input logic ld, input logic [7:0] lv, input logic clr);
    bus0.en = e;  bus0.dir = d;  bus0.odd = o;  bus0.load = ld;  bus0.load_val = lv;  bus0.clr_ovf = clr;
    bus1.en = e;  bus1.dir = d;  bus1.odd = o;  bus1.load = ld;  bus1.load_val = lv;  bus1.clr_ovf = clr;
  endtask

  // One clock: drive on the falling edge, check at_limit, push the model's
  // prediction, then pop and compare just after the rising edge.
  task automatic cycle(input logic e, input logic d, input logic o,
                       input logic ld, input logic [7:0] lv, input logic clr);
    exp_t x;
    logic [6:0] c;
    @(negedge clk);
    set_inputs(e, d, o, ld, lv, clr);
    #1;
    c = mq[0][7:1];
    check_val("wrap.at_limit", {31'd0, bus0.at_limit}, {31'd0, d ? (c == 7'd0) : (c == 7'h7F)});
    c = mq[1][7:1];
    check_val("sat.at_limit", {31'd0, bus1.at_limit}, {31'd0, d ? (c == 7'd0) : (c == 7'h7F)});
    model_step(0, e, d, o, ld, lv, clr);
    model_step(1, e, d, o, ld, lv, clr);
    sb0.push_back('{q: mq[0], tc: mtc[0], ovf: movf[0]});
    sb1.push_back('{q: mq[1], tc: mtc[1], ovf: movf[1]});
    @(posedge clk);
    #1;
    x = sb0.pop_front();
    check_val("wrap.q",   {24'd0, bus0.q},   {24'd0, x.q});
    check_val("wrap.tc",  {31'd0, bus0.tc},  {31'd0, x.tc});
    check_val("wrap.ovf", {31'd0, bus0.ovf}, {31'd0, x.ovf});
    x = sb1.pop_front();
    check_val("sat.q",    {24'd0, bus1.q},   {24'd0, x.q});
    check_val("sat.tc",   {31'd0, bus1.tc},  {31'd0, x.tc});
    check_val("sat.ovf",  {31'd0, bus1.ovf}, {31'd0, x.ovf});
  endtask

  // Asynchronous reset between edges, held across one enabled edge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_val("rst.wrap.q",   {24'd0, bus0.q},   32'd0);
    check_val("rst.wrap.tc",  {31'd0, bus0.tc},  32'd0);
    check_val("rst.wrap.ovf", {31'd0, bus0.ovf}, 32'd0);
    check_val("rst.sat.q",    {24'd0, bus1.q},   32'd0);
    check_val("rst.sat.ovf",  {31'd0, bus1.ovf}, 32'd0);
    set_inputs(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check_val("rst.hold.wrap.q", {24'd0, bus0.q}, 32'd0);
    check_val("rst.hold.sat.q",  {24'd0, bus1.q}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      mq[k] = 8'h00; mtc[k] = 1'b0; movf[k] = 1'b0;
    end
    sb0.delete();
    sb1.delete();
    @(negedge clk);
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 2; k++) begin
      mq[k] = 8'h00; mtc[k] = 1'b0; movf[k] = 1'b0;
    end
    #12;
    check_val("init.wrap.q",   {24'd0, bus0.q},   32'd0);
    check_val("init.wrap.ovf", {31'd0, bus0.ovf}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Full even sweep up through the wrap.
    for (int i = 0; i < 130; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Odd load, odd steps, then parity change on an enabled step.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 1'b0);
    check_val("load.odd", {24'd0, bus0.q}, 32'h11);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_val("parity.switch", {24'd0, bus0.q}, 32'h18);

    // Down through zero, then a lone clr_ovf.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    check_val("down.wrap", {24'd0, bus0.q}, 32'hFE);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    check_val("clr.ovf", {31'd0, bus0.ovf}, 32'd0);

    // Up into the top limit; clr_ovf coincides with a limit hit.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'hFC, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_val("sat.hold",  {24'd0, bus1.q},   32'hFE);
    check_val("sat.ovf1",  {31'd0, bus1.ovf}, 32'd1);

    // Load beats enable.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0);
    check_val("load.pri", {24'd0, bus0.q}, 32'h40);

    // Set ovf, park at 0x36, then reset asynchronously.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h36, 1'b0);
    check_val("pre.rst.ovf", {31'd0, bus0.ovf}, 32'd1);
    async_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check_val("post.rst", {24'd0, bus0.q}, 32'h02);

    // Random mix of all controls.
    for (int i = 0; i < 80; i++) begin
      cycle(($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 5) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
